sequential_simple_sub_circuit: RTL
==================================

// Module: sequential_simple_sub_circuit
// PURPOSE
//   Decode stage for the +1 stream produced by sequentialSimpleAdd_Circuit.
//   Computes O0 = I0 - DEC through one registered stage with a 2-entry skid buffer.
//   Uses ready/valid handshakes on both sides and supports full throughput.
//   Placed downstream of the add stage, so the add/sub pair forms an identity pipeline.
// PARAMETERS
//   WIDTH   8   data width of I0/O0
//   DEC     1   constant subtracted; only the low WIDTH bits are used
//   CNT_W   16  width of tx_count (only used with SEQ_SUB_COUNT_EN)
// PORTS
//   CLK             in   1      clock, rising edge
//   ASYNCRESETN     in   1      asynchronous, active-low reset
//   CE              in   1      clock enable; when low, all state holds
//   I0              in   WIDTH  upstream data
//   valid_data_in   in   1      upstream data valid
//   ready_data_in   out  1      this block can accept data
//   O0              out  WIDTH  decoded data
//   valid_data_out  out  1      O0 valid
//   ready_data_out  in   1      downstream can accept
//   tx_count        out  CNT_W  output transfer count (SEQ_SUB_COUNT_EN only)
// BEHAVIOUR
//   - Reset (ASYNCRESETN=0, takes effect immediately, no CLK needed):
//     main_v=0, skid_v=0, O0=0, valid_data_out=0, ready_data_in=1, tx_count=0.
//   - Reset mid-operation discards all buffered data without emitting it.
//   - Accept condition: acc = CE & valid_data_in & ready_data_in.
//   - Emit condition:   emt = CE & valid_data_out & ready_data_out.
//   - Arithmetic: O0 = (I0 - DEC) mod 2^WIDTH, computed at accept time.
//     Wraps, e.g. 8'h00 -> 8'hFF. No saturation, no flag.
//   - Latency: 1 cycle from accept to valid_data_out when the stage is empty.
//   - Throughput: 1 transfer per cycle when ready_data_out is held high.
//   - O0, valid_data_out and ready_data_in are register outputs.
//     ready_data_in = ~skid_v, so there is no combinational in->out ready path.
//   - State {main_v, skid_v} and transitions on a CLK edge with CE=1:
//     EMPTY (0,0): acc -> main<=dec(I0), go to ONE.
//     ONE   (1,0): acc & emt -> main<=dec(I0), stay ONE.
//                  acc & ~emt -> skid<=dec(I0), go to FULL.
//                  ~acc & emt -> go to EMPTY.
//     FULL  (1,1): ready_data_in=0, so acc cannot occur.
//                  emt -> main<=skid, go to ONE.
//   - While valid_data_out=1 and ready_data_out=0, O0 holds stable.
//   - CE=0: no state changes, acc=emt=0, outputs hold their current values.
//   - Order is preserved; no data is dropped or duplicated.
// CONFIGURATION
//   SEQ_SUB_COUNT_EN defined:
//     tx_count port exists.
//     tx_count increments by 1 on each emt and wraps at 2^CNT_W.
//     Resets to 0.
//   SEQ_SUB_COUNT_EN undefined:
//     tx_count port and its counter are absent; all other behaviour is identical.
// TESTING
//   1. Reset, then send 8'h05 with ready_data_out=1
//      -> next cycle O0=8'h04, valid_data_out=1.
//   2. Send 8'h00
//      -> O0=8'hFF (wrap).
//   3. Hold ready_data_out=0 and send 8'h10 then 8'h20
//      -> ready_data_in=0 after the 2nd accept; O0 holds 8'h0F.
//      Then release ready_data_out -> outputs 8'h0F, 8'h1F in order.
//   4. Stream 0x01..0x40 with ready_data_out=1, valid_data_in=1
//      -> one output per cycle, values 0x00..0x3F.
//      tx_count=64 (with SEQ_SUB_COUNT_EN).
//   5. Drive CE=0 for 3 cycles while valid_data_in=1 and ready_data_out=1
//      -> no accepts, O0/valid_data_out unchanged, tx_count unchanged.
//   6. Assert ASYNCRESETN=0 between edges while in FULL
//      -> immediately valid_data_out=0, ready_data_in=1, O0=0.
//   7. Chain sequentialSimpleAdd_Circuit -> this block with random stalls
//      -> output stream equals input stream.

Source files
------------

// File: rtl/sequential_simple_sub_circuit.sv
// rtl/sequential_simple_sub_circuit.sv - registered O0 = I0 - DEC stage with 2-entry skid buffer (optional tx_count via SEQ_SUB_COUNT_EN)
module sequential_simple_sub_circuit #(
  parameter int WIDTH = 8,
  parameter int DEC   = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             CE,
  input  logic [WIDTH-1:0] I0,
  input  logic             valid_data_in,
  output logic             ready_data_in,
  output logic [WIDTH-1:0] O0,
  output logic             valid_data_out,
  input  logic             ready_data_out
`ifdef SEQ_SUB_COUNT_EN
  ,
  output logic [CNT_W-1:0] tx_count
`endif
);

  // Only the low WIDTH bits of DEC take part in the subtraction.
  localparam logic [WIDTH-1:0] DEC_W = WIDTH'(DEC);

  // Encoding is {main_v, skid_v}, so the outputs come straight off state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] dec_in;
  logic             acc;
  logic             emt;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  // Reject nonsensical widths at elaboration time.
  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  assign dec_in         = I0 - DEC_W;
  assign valid_data_out = state[1];
  assign ready_data_in  = ~state[0];
  assign acc            = CE & valid_data_in & ready_data_in;
  assign emt            = CE & valid_data_out & ready_data_out;

  // State register; reset discards anything buffered.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next state and data-path load selects from the accept/emit pair.
  always_comb begin
    state_n        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          load_main_in = 1'b1;
          state_n      = ONE;
        end
      end
      ONE: begin
        if (acc && emt) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          load_skid = 1'b1;
          state_n   = FULL;
        end else if (emt) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (emt) begin
          load_main_skid = 1'b1;
          state_n        = ONE;
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
  end

  // Main output register; holds its value whenever nothing is loaded.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      O0 <= '0;
    end else if (load_main_in) begin
      O0 <= dec_in;
    end else if (load_main_skid) begin
      O0 <= skid_q;
    end
  end

  // Skid register catches the word accepted while the output is stalled.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= dec_in;
    end
  end

`ifdef SEQ_SUB_COUNT_EN
  // Count completed output transfers, wrapping naturally.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      tx_count <= '0;
    end else if (emt) begin
      tx_count <= tx_count + CNT_W'(1);
    end
  end
`endif

endmodule
